i8080_fetch_queue: RTL and testbench
====================================

# i8080_fetch_queue

Instruction fetch stage for the pipelined 8080 core, sitting directly upstream of decode. It streams opcode bytes from a byte-wide memory read port into a circular prefetch queue and determines each instruction's length (1/2/3 bytes) from its opcode. It presents one whole instruction per handshake to decode in the `{opcode, lb, hb}` 24-bit format decode already consumes. It supports redirect for jumps, calls, returns, RST and PCHL.

## Interface
Parameters:
- `DEPTH`, default 8: queue size in bytes; power of two, minimum 4.
- `RESET_PC`, default 16'h0000: fetch address after reset.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `mem_req` out 1: byte read request.
- `mem_addr` out 16: address for `mem_req`.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: read data valid; exactly one cycle after each accepted request.
- `mem_rdata` in 8: returned byte.
- `instr_valid` out 1: complete instruction at queue head.
- `instr_ready` in 1: decode accepts.
- `instr` out 24: [23:16] opcode, [15:8] lb, [7:0] hb; unused bytes are 0.
- `instr_len` out 2: 1, 2 or 3.
- `instr_pc` out 16: address of the opcode.
- `redirect` in 1: flush and restart fetch.
- `redirect_pc` in 16: new fetch address.

## Operation
- **State:**
  - Byte array `q[DEPTH]`.
  - `head`/`tail` pointers, log2(DEPTH)+1 bits, where the MSB is the wrap bit.
  - `count` = tail − head.
  - `fetch_pc`: next address to request.
  - `head_pc`: address of `q[head]`.
  - `pend`: 1 if an accepted request's data is due next cycle.
- **Request:** `mem_req = !redirect && (count + pend + 1 <= DEPTH)`. `mem_addr = fetch_pc`. On `mem_req && mem_gnt`, `fetch_pc` increments by 1 (16-bit wrap, 16'hFFFF→16'h0000) and `pend` is set to 1 for the next cycle.
- **Fill:** when `mem_rvalid && !redirect`, write `q[tail] <= mem_rdata` and increment `tail`.
- **Length decode**, applied to `q[head]`:
  - 3 bytes: LXI (00rp0001), SHLD 22, LHLD 2A, STA 32, LDA 3A, JMP C3/CB, Jccc (11ccc010), CALL CD/DD/ED/FD, Cccc (11ccc100).
  - 2 bytes: MVI (00ddd110), ADI C6, ACI CE, SUI D6, SBI DE, ANI E6, XRI EE, ORI F6, CPI FE, OUT D3, IN DB.
  - All other opcodes: 1 byte.
- **Output:** `instr_valid = !redirect && count >= 1 && count >= len`. `instr = {q[head], len>=2 ? q[head+1] : 0, len==3 ? q[head+2] : 0}`. When `instr_valid` is 0, `instr` is don't-care.
- **Pop:** on `instr_valid && instr_ready`, `head += len` and `head_pc += len` (mod 2^16). Push and pop in the same cycle update `count` by (+1 − len).
- **Redirect** has priority over everything else:
  - `head = tail = 0`, `fetch_pc = head_pc = redirect_pc`, `pend = 0`.
  - A `mem_rvalid` arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle, because `mem_req` is gated by `redirect`.
  - `instr_ready` is ignored in the redirect cycle.
- **Reset** (asynchronous assert, synchronous release; pointers, `count` and `pend` all zero):
  - `mem_req` = 0 while `rst_n` = 0; `mem_addr` = `RESET_PC`.
  - `instr_valid` = 0; `instr` = 0; `instr_len` = 1; `instr_pc` = `RESET_PC`.
  - Reset mid-operation drops all in-flight data; a `mem_rvalid` in the first cycle after release is ignored because `pend` = 0.
- **Stray returns:** `mem_rvalid` while `pend` = 0 is ignored.

## Timing
- Throughput: one byte per cycle into the queue, and at most one instruction per cycle out.
- After reset release, with `mem_gnt` held at 1 and `rdata` returning one cycle after each request:
  - 1-byte opcode at `RESET_PC`: `instr_valid` at cycle 2.
  - 3-byte opcode at `RESET_PC`: `instr_valid` at cycle 4.
- Redirect at cycle t: the first request to `redirect_pc` is at t+1, and the earliest `instr_valid` is at t+3.
- Full: when `count + pend == DEPTH`, `mem_req` = 0. A pop frees space, and a new request can issue in the same cycle the pop's result is registered (next cycle).
- All outputs except `mem_req` and `instr_valid` are pure functions of registers. Those two also combinationally depend on `redirect`.

## Structure
- Package `i8080_pkg`:
  - Opcode constants for the 2- and 3-byte classes.
  - `typedef logic [1:0] ilen_t`.
  - Instruction field positions: OPC [23:16], LB [15:8], HB [7:0].
  - Decode reuses these constants.
- Sub-module `i8080_len_decode`: combinational, 8-bit opcode in, `ilen_t` out. It is shared with any future predecode logic.

## Test plan
- **Straight-line fetch:** memory holds 00 3E 55 C3 34 12. Required: three instructions (000000, len 1, pc 0), (3E5500, len 2, pc 1), (C33412, len 3, pc 3).
- **Backpressure fill:** `instr_ready` = 0 with `DEPTH` = 8. Required: exactly 8 requests (addresses 0–7), then `mem_req` stays 0. Raising `instr_ready` resumes requests at address 8.
- **Redirect with in-flight read:** request to 5 granted at cycle t, `redirect` with `redirect_pc` 16'h0100 at t+1. Required: byte from 5 is discarded, next `mem_addr` is 0100, and the first `instr_pc` is 0100.
- **Split instruction:** `mem_gnt` pulsed every third cycle for CD 00 20. Required: `instr_valid` stays 0 until the third byte is stored, then shows CD0020.
- **Address wrap:** `redirect_pc` FFFF with a 3-byte opcode. Required: bytes fetched from FFFF, 0000, 0001, and `head_pc` becomes 0002.
- **Async reset:** `rst_n` pulsed low mid-operation with a non-full queue. Required: `instr_valid` drops immediately, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/i8080_pkg.sv
// i8080_pkg
// Shared definitions for the 8080 front end: instruction length type,
// field positions of the 24-bit {opcode, lb, hb} instruction word, and the
// opcode constants/patterns that select 2- and 3-byte instructions.
// No ports (package).
package i8080_pkg;

    typedef logic [1:0] ilen_t;

    localparam ilen_t ILEN_1 = 2'd1;
    localparam ilen_t ILEN_2 = 2'd2;
    localparam ilen_t ILEN_3 = 2'd3;

    // Instruction word field positions
    localparam int OPC_MSB = 23;
    localparam int OPC_LSB = 16;
    localparam int LB_MSB  = 15;
    localparam int LB_LSB  = 8;
    localparam int HB_MSB  = 7;
    localparam int HB_LSB  = 0;

    // 3-byte opcodes
    localparam logic [7:0] OPC_SHLD      = 8'h22;
    localparam logic [7:0] OPC_LHLD      = 8'h2A;
    localparam logic [7:0] OPC_STA       = 8'h32;
    localparam logic [7:0] OPC_LDA       = 8'h3A;
    localparam logic [7:0] OPC_JMP       = 8'hC3;
    localparam logic [7:0] OPC_JMP_ALT   = 8'hCB;
    localparam logic [7:0] OPC_CALL      = 8'hCD;
    localparam logic [7:0] OPC_CALL_ALT1 = 8'hDD;
    localparam logic [7:0] OPC_CALL_ALT2 = 8'hED;
    localparam logic [7:0] OPC_CALL_ALT3 = 8'hFD;

    // 3-byte opcode families (mask/match)
    localparam logic [7:0] LXI_MASK  = 8'hCF;  // 00rp0001
    localparam logic [7:0] LXI_MATCH = 8'h01;
    localparam logic [7:0] JCC_MASK  = 8'hC7;  // 11ccc010
    localparam logic [7:0] JCC_MATCH = 8'hC2;
    localparam logic [7:0] CCC_MASK  = 8'hC7;  // 11ccc100
    localparam logic [7:0] CCC_MATCH = 8'hC4;

    // 2-byte opcodes
    localparam logic [7:0] OPC_ADI = 8'hC6;
    localparam logic [7:0] OPC_ACI = 8'hCE;
    localparam logic [7:0] OPC_SUI = 8'hD6;
    localparam logic [7:0] OPC_SBI = 8'hDE;
    localparam logic [7:0] OPC_ANI = 8'hE6;
    localparam logic [7:0] OPC_XRI = 8'hEE;
    localparam logic [7:0] OPC_ORI = 8'hF6;
    localparam logic [7:0] OPC_CPI = 8'hFE;
    localparam logic [7:0] OPC_OUT = 8'hD3;
    localparam logic [7:0] OPC_IN  = 8'hDB;

    // 2-byte opcode family
    localparam logic [7:0] MVI_MASK  = 8'hC7;  // 00ddd110
    localparam logic [7:0] MVI_MATCH = 8'h06;

    function automatic logic opc_match(input logic [7:0] opc,
                                       input logic [7:0] mask,
                                       input logic [7:0] match);
        return (opc & mask) == match;
    endfunction

endpackage

// File: rtl/i8080_len_decode.sv
// i8080_len_decode
// Combinational instruction length decode from the opcode byte.
// Ports:
//   opcode  in  8  opcode byte
//   len     out 2  instruction length in bytes (1, 2 or 3)
module i8080_len_decode
    import i8080_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    always_comb begin
        len = ILEN_1;
        if (opc_match(opcode, LXI_MASK, LXI_MATCH) ||
            opc_match(opcode, JCC_MASK, JCC_MATCH) ||
            opc_match(opcode, CCC_MASK, CCC_MATCH)) begin
            len = ILEN_3;
        end else if (opc_match(opcode, MVI_MASK, MVI_MATCH)) begin
            len = ILEN_2;
        end else begin
            case (opcode)
                OPC_SHLD, OPC_LHLD, OPC_STA, OPC_LDA,
                OPC_JMP, OPC_JMP_ALT,
                OPC_CALL, OPC_CALL_ALT1, OPC_CALL_ALT2, OPC_CALL_ALT3:
                    len = ILEN_3;
                OPC_ADI, OPC_ACI, OPC_SUI, OPC_SBI,
                OPC_ANI, OPC_XRI, OPC_ORI, OPC_CPI,
                OPC_OUT, OPC_IN:
                    len = ILEN_2;
                default:
                    len = ILEN_1;
            endcase
        end
    end

endmodule

// File: rtl/i8080_fetch_queue.sv
// i8080_fetch_queue
// Instruction fetch stage: streams bytes from a byte-wide memory port into a
// circular prefetch queue and hands whole instructions ({opcode, lb, hb})
// to decode, one per handshake. Redirect flushes the queue and restarts fetch.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   mem_req/mem_addr      byte read request and its address
//   mem_gnt               request accepted this cycle
//   mem_rvalid/mem_rdata  read data, one cycle after each accepted request
//   instr_valid/ready     instruction handshake to decode
//   instr                 [23:16] opcode, [15:8] lb, [7:0] hb (unused bytes 0)
//   instr_len             1, 2 or 3
//   instr_pc              address of the opcode
//   redirect/redirect_pc  flush and restart fetch at redirect_pc
module i8080_fetch_queue
    import i8080_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [23:0] instr,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;   // extra MSB is the wrap bit

    logic [7:0]    q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] count;
    logic [15:0]   fetch_pc;
    logic [15:0]   head_pc;
    logic          pend;

    logic [AW-1:0] h0, h1, h2;
    ilen_t         dec_len;
    logic [PW-1:0] len_ext;
    logic          have_head;
    logic          whole;
    logic [PW:0]   occupancy;
    logic          push;
    logic          pop;

    assign count = tail - head;
    assign h0    = head[AW-1:0];
    assign h1    = h0 + AW'(1);
    assign h2    = h0 + AW'(2);

    i8080_len_decode u_len_decode (
        .opcode (q[h0]),
        .len    (dec_len)
    );

    assign len_ext   = PW'(dec_len);
    assign have_head = (count != '0);
    // All bytes of the head instruction are present; registers only.
    assign whole     = have_head && (count >= len_ext);

    // Bytes stored plus the one in flight plus the one about to be requested.
    assign occupancy = {1'b0, count} + (PW+1)'(pend) + (PW+1)'(1);

    // rst_n gating keeps the bus quiet while reset is held.
    assign mem_req     = rst_n && !redirect && (occupancy <= (PW+1)'(DEPTH));
    assign mem_addr    = fetch_pc;
    assign instr_valid = !redirect && whole;
    assign instr_pc    = head_pc;
    // Queue slots are not reset, so outputs are forced to known values
    // whenever the head instruction is incomplete.
    assign instr_len   = have_head ? dec_len : ILEN_1;

    always_comb begin
        instr = '0;
        if (whole) begin
            instr[OPC_MSB:OPC_LSB] = q[h0];
            if (dec_len >= ILEN_2) instr[LB_MSB:LB_LSB] = q[h1];
            if (dec_len == ILEN_3) instr[HB_MSB:HB_LSB] = q[h2];
        end
    end

    // Returns without an outstanding request (stray, or first cycle after
    // reset/redirect) are dropped because pend is 0.
    assign push = mem_rvalid && pend && !redirect;
    assign pop  = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            pend     <= 1'b0;
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
        end else if (redirect) begin
            head     <= '0;
            tail     <= '0;
            pend     <= 1'b0;
            fetch_pc <= redirect_pc;
            head_pc  <= redirect_pc;
        end else begin
            pend <= mem_req && mem_gnt;
            if (mem_req && mem_gnt) fetch_pc <= fetch_pc + 16'd1;
            if (push) tail <= tail + PW'(1);
            if (pop) begin
                head    <= head + len_ext;
                head_pc <= head_pc + 16'(dec_len);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) q[tail[AW-1:0]] <= mem_rdata;
    end

endmodule

// File: tb/tb_i8080_fetch_queue.sv
module tb_i8080_fetch_queue;

    localparam int          DEPTH    = 8;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [23:0] instr;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;

    i8080_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_len   (instr_len),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [65536];
    int          ltab [256];
    logic [7:0]  mq [$];
    int          m_pend;
    logic [15:0] m_fetch;
    logic [15:0] m_hpc;
    logic [41:0] ilog [$];
    logic [15:0] rlog [$];
    logic        stray_en;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend  = 0;
        m_fetch = RESET_PC;
        m_hpc   = RESET_PC;
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, then
    // act as the memory for the next cycle.
    task automatic step();
        int          len0;
        logic        e_req, e_valid, acc;
        logic [23:0] e_instr;
        logic [15:0] acc_addr;
        acc      = 1'b0;
        acc_addr = '0;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_mem_req", 48'(mem_req), 48'(0));
            chk("rst_valid", 48'(instr_valid), 48'(0));
            chk("rst_instr", 48'(instr), 48'(0));
            chk("rst_len", 48'(instr_len), 48'(1));
            chk("rst_pc", 48'(instr_pc), 48'(RESET_PC));
            chk("rst_addr", 48'(mem_addr), 48'(RESET_PC));
            model_reset();
        end else begin
            len0    = (mq.size() > 0) ? ltab[mq[0]] : 1;
            e_req   = !redirect && (mq.size() + m_pend + 1 <= DEPTH);
            e_valid = !redirect && (mq.size() >= 1) && (mq.size() >= len0);
            chk("mem_req", 48'(mem_req), 48'(e_req));
            chk("mem_addr", 48'(mem_addr), 48'(m_fetch));
            chk("instr_valid", 48'(instr_valid), 48'(e_valid));
            chk("instr_pc", 48'(instr_pc), 48'(m_hpc));
            if (e_valid) begin
                e_instr = {mq[0], (len0 >= 2) ? mq[1] : 8'h00, (len0 == 3) ? mq[2] : 8'h00};
                chk("instr", 48'(instr), 48'(e_instr));
                chk("instr_len", 48'(instr_len), 48'(len0));
            end
            acc      = mem_req && mem_gnt;
            acc_addr = mem_addr;
            if (acc) rlog.push_back(mem_addr);
            if (instr_valid && instr_ready) ilog.push_back({instr, instr_len, instr_pc});
            if (redirect) begin
                mq.delete();
                m_fetch = redirect_pc;
                m_hpc   = redirect_pc;
                m_pend  = 0;
            end else begin
                if (e_valid && instr_ready) begin
                    repeat (len0) void'(mq.pop_front());
                    m_hpc = m_hpc + 16'(len0);
                end
                if (mem_rvalid && m_pend != 0) mq.push_back(mem_rdata);
                m_pend = (e_req && mem_gnt) ? 1 : 0;
                if (e_req && mem_gnt) m_fetch = m_fetch + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem[acc_addr];
        end else if (stray_en && $urandom_range(0, 3) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 8'($urandom);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect    = 1'b0;
    endtask

    int l3 [10] = '{8'h22, 8'h2A, 8'h32, 8'h3A, 8'hC3, 8'hCB, 8'hCD, 8'hDD, 8'hED, 8'hFD};
    int l2 [10] = '{8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hD3, 8'hDB};

    initial begin
        rst_n       = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 8'h00;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        stray_en    = 1'b0;

        // Length table from the opcode class lists.
        for (int i = 0; i < 256; i++) ltab[i] = 1;
        for (int rp = 0; rp < 4; rp++) ltab[rp * 16 + 1] = 3;
        for (int c = 0; c < 8; c++) begin
            ltab[192 + c * 8 + 2] = 3;
            ltab[192 + c * 8 + 4] = 3;
            ltab[c * 8 + 6]       = 2;
        end
        for (int i = 0; i < 10; i++) begin
            ltab[l3[i]] = 3;
            ltab[l2[i]] = 2;
        end

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h00; mem[1] = 8'h3E; mem[2] = 8'h55;
        mem[3] = 8'hC3; mem[4] = 8'h34; mem[5] = 8'h12;
        model_reset();

        // Straight-line fetch
        do_reset();
        instr_ready = 1'b1;
        mem_gnt     = 1'b1;
        ilog.delete();
        repeat (10) step();
        chk("sl_count_ge3", 48'(ilog.size() >= 3), 48'(1));
        if (ilog.size() >= 3) begin
            chk("sl_instr0", 48'(ilog[0]), 48'({24'h000000, 2'd1, 16'h0000}));
            chk("sl_instr1", 48'(ilog[1]), 48'({24'h3E5500, 2'd2, 16'h0001}));
            chk("sl_instr2", 48'(ilog[2]), 48'({24'hC33412, 2'd3, 16'h0003}));
        end

        // Backpressure fill
        do_reset();
        instr_ready = 1'b0;
        mem_gnt     = 1'b1;
        rlog.delete();
        repeat (14) step();
        chk("bp_req_count", 48'(rlog.size()), 48'(8));
        if (rlog.size() == 8) chk("bp_last_addr", 48'(rlog[7]), 48'(16'h0007));
        instr_ready = 1'b1;
        rlog.delete();
        repeat (4) step();
        chk("bp_resume_any", 48'(rlog.size() >= 1), 48'(1));
        if (rlog.size() >= 1) chk("bp_resume_addr", 48'(rlog[0]), 48'(16'h0008));

        // Redirect with an in-flight read of address 5
        mem[16'h0100] = 8'h06;
        mem[16'h0101] = 8'h77;
        do_reset();
        instr_ready = 1'b0;
        mem_gnt     = 1'b1;
        rlog.delete();
        repeat (6) step();
        chk("rd_inflight_addr", 48'(rlog[rlog.size() - 1]), 48'(16'h0005));
        do_redirect(16'h0100);
        instr_ready = 1'b1;
        rlog.delete();
        ilog.delete();
        repeat (6) step();
        chk("rd_first_req", 48'(rlog.size() >= 1 ? rlog[0] : 16'hDEAD), 48'(16'h0100));
        chk("rd_first_instr", 48'(ilog.size() >= 1 ? ilog[0] : 42'h0), 48'({24'h067700, 2'd2, 16'h0100}));

        // Split instruction with sparse grants
        mem[16'h0200] = 8'hCD;
        mem[16'h0201] = 8'h00;
        mem[16'h0202] = 8'h20;
        do_redirect(16'h0200);
        ilog.delete();
        for (int k = 0; k < 12; k++) begin
            mem_gnt = (k % 3 == 0);
            step();
        end
        chk("split_instr", 48'(ilog.size() >= 1 ? ilog[0] : 42'h0), 48'({24'hCD0020, 2'd3, 16'h0200}));

        // Address wrap
        mem[16'hFFFF] = 8'hC3;
        mem[16'h0000] = 8'h11;
        mem[16'h0001] = 8'h22;
        mem[16'h0002] = 8'h00;
        mem_gnt = 1'b1;
        do_redirect(16'hFFFF);
        rlog.delete();
        ilog.delete();
        repeat (7) step();
        chk("wrap_req_count", 48'(rlog.size() >= 3), 48'(1));
        if (rlog.size() >= 3) begin
            chk("wrap_req0", 48'(rlog[0]), 48'(16'hFFFF));
            chk("wrap_req1", 48'(rlog[1]), 48'(16'h0000));
            chk("wrap_req2", 48'(rlog[2]), 48'(16'h0001));
        end
        chk("wrap_instr", 48'(ilog.size() >= 1 ? ilog[0] : 42'h0), 48'({24'hC31122, 2'd3, 16'hFFFF}));
        chk("wrap_head_pc", 48'(ilog.size() >= 2 ? ilog[1][15:0] : 16'hDEAD), 48'(16'h0002));

        // Asynchronous reset mid-operation with a partially filled queue
        instr_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("async_valid_drop", 48'(instr_valid), 48'(0));
        chk("async_req_drop", 48'(mem_req), 48'(0));
        repeat (2) step();
        rst_n = 1'b1;
        instr_ready = 1'b1;
        rlog.delete();
        repeat (3) step();
        chk("async_restart_addr", 48'(rlog.size() >= 1 ? rlog[0] : 16'hDEAD), 48'(RESET_PC));

        // Randomized traffic against the reference model
        stray_en = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            mem_gnt     = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 40) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 16'h0000;
                1:       redirect_pc = 16'h0300;
                2:       redirect_pc = 16'hFFFE;
                default: redirect_pc = 16'($urandom);
            endcase
            step();
        end
        redirect = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
